// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage sitting directly upstream of the Controller in the
// multi-cycle core. Owns the PC, fetches one instruction word per FETCH/ISSUE
// round over a req/ack handshake, holds it in the instruction register, and
// computes the next PC from the Controller's PC-source selects.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   imem_req/imem_addr  fetch request (FETCH state) and address (always pc)
//   imem_ack/imem_rdata memory response; accepted only in FETCH
//   stall               hold the current instruction in ISSUE
//   sel_PCSrc_*         Controller PC-source selects (expected one-hot)
//   branch_taken        branch condition, qualifies sel_PCSrc_offset
//   jump_offset         signed branch offset relative to pc+1
//   jump_target         absolute jump target
//   instr/opcode        instruction register and its top 6 bits
//   instr_valid         instr/opcode valid (ISSUE state)
//   pc                  current PC
//   sel_error           one-cycle pulse after an issue with non-one-hot selects
//   instr_count         number of issued instructions, wraps at 2^16
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int              PC_W     = 12,
  parameter int              INSTR_W  = 19,
  parameter int              OFF_W    = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               sel_PCSrc_plus1,
  input  logic               sel_PCSrc_offset,
  input  logic               sel_PCSrc_const,
  input  logic               branch_taken,
  input  logic [OFF_W-1:0]   jump_offset,
  input  logic [PC_W-1:0]    jump_target,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               sel_error,
  output logic [15:0]        instr_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t               state_r;
  state_t               state_next_s;
  logic [PC_W-1:0]      pc_r;
  logic [PC_W-1:0]      pc_next_s;
  logic [PC_W-1:0]      pc_plus1_s;
  logic [PC_W-1:0]      off_ext_s;
  logic [INSTR_W-1:0]   instr_r;
  logic [15:0]          instr_count_r;
  logic                 sel_error_r;
  logic [1:0]           sel_cnt_s;
  logic                 issue_fire_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; imem_ack outside FETCH has no effect
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE:  state_next_s = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        if (stall) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_r)
      ST_FETCH: imem_req    = 1'b1;
      ST_ISSUE: instr_valid = 1'b1;
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  // Next-PC select: const beats taken offset beats the pc+1 fall-through.
  // The offset is relative to pc+1 and all arithmetic wraps at 2^PC_W.
  always_comb begin
    off_ext_s    = {{(PC_W-OFF_W){jump_offset[OFF_W-1]}}, jump_offset};
    pc_plus1_s   = pc_r + PC_ONE;
    sel_cnt_s    = {1'b0, sel_PCSrc_plus1} + {1'b0, sel_PCSrc_offset} + {1'b0, sel_PCSrc_const};
    issue_fire_s = (state_r == ST_ISSUE) && !stall;
    if (sel_PCSrc_const) begin
      pc_next_s = jump_target;
    end else if (sel_PCSrc_offset && branch_taken) begin
      pc_next_s = pc_plus1_s + off_ext_s;
    end else begin
      pc_next_s = pc_plus1_s;
    end
  end

  // Datapath registers: instruction capture, PC update, issue count, select check
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      instr_r       <= '0;
      instr_count_r <= 16'd0;
      sel_error_r   <= 1'b0;
    end else begin
      sel_error_r <= 1'b0;
      if ((state_r == ST_FETCH) && imem_ack) begin
        instr_r <= imem_rdata;
      end
      if (issue_fire_s) begin
        pc_r          <= pc_next_s;
        instr_count_r <= instr_count_r + 16'd1;
        sel_error_r   <= (sel_cnt_s != 2'd1);
      end
    end
  end

  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign instr       = instr_r;
  assign opcode      = instr_r[INSTR_W-1:INSTR_W-6];
  assign sel_error   = sel_error_r;
  assign instr_count = instr_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A table of branch/jump vectors is applied in
// a loop (each vector first jumps to its start PC, then issues with the
// vector's selects); hand-written sequences cover reset, ack latency, stall
// and asynchronous reset in FETCH and ISSUE.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [18:0] imem_rdata;
  logic        stall;
  logic        sel_PCSrc_plus1;
  logic        sel_PCSrc_offset;
  logic        sel_PCSrc_const;
  logic        branch_taken;
  logic [7:0]  jump_offset;
  logic [11:0] jump_target;
  logic [18:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [11:0] pc;
  logic        sel_error;
  logic [15:0] instr_count;

  int          checks;
  int          failures;
  logic [15:0] exp_count;

  fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .stall            (stall),
    .sel_PCSrc_plus1  (sel_PCSrc_plus1),
    .sel_PCSrc_offset (sel_PCSrc_offset),
    .sel_PCSrc_const  (sel_PCSrc_const),
    .branch_taken     (branch_taken),
    .jump_offset      (jump_offset),
    .jump_target      (jump_target),
    .instr            (instr),
    .opcode           (opcode),
    .instr_valid      (instr_valid),
    .pc               (pc),
    .sel_error        (sel_error),
    .instr_count      (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] start_pc;
    logic        p1;
    logic        of;
    logic        cs;
    logic        tk;
    logic [7:0]  offv;
    logic [11:0] tgt;
    logic [11:0] exp_addr;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  // Memory contents: a word derived from the address so every fetch is distinct
  function automatic logic [18:0] word(input logic [11:0] a);
    word = {a[6:0] ^ 7'h55, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_sel(input logic p1, input logic of, input logic cs, input logic tk,
                         input logic [7:0] offv, input logic [11:0] tgt);
    sel_PCSrc_plus1  = p1;
    sel_PCSrc_offset = of;
    sel_PCSrc_const  = cs;
    branch_taken     = tk;
    jump_offset      = offv;
    jump_target      = tgt;
  endtask

  // One FETCH (lat wait cycles, then ack) + ISSUE (stalls cycles, then release).
  // Called at a negedge with the DUT in FETCH; returns at the negedge after the
  // issue edge, when the DUT is back in FETCH at the next address.
  task automatic run_instr(input int lat, input logic p1, input logic of, input logic cs,
                           input logic tk, input logic [7:0] offv, input logic [11:0] tgt,
                           input int stalls);
    logic [11:0] a;
    logic [18:0] w;
    a = imem_addr;
    w = word(a);
    chk("req_fetch", {31'd0, imem_req}, 32'd1);
    chk("valid_fetch", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < lat; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = ~w;
      @(negedge clk);
      if (i == 0) chk("sel_err_clear", {31'd0, sel_error}, 32'd0);
      chk("addr_hold", {20'd0, imem_addr}, {20'd0, a});
      chk("req_hold", {31'd0, imem_req}, 32'd1);
      chk("valid_wait", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 19'd0;
    if (lat == 0) chk("sel_err_clear", {31'd0, sel_error}, 32'd0);
    chk("valid_issue", {31'd0, instr_valid}, 32'd1);
    chk("req_issue", {31'd0, imem_req}, 32'd0);
    chk("instr", {13'd0, instr}, {13'd0, w});
    chk("opcode", {26'd0, opcode}, {26'd0, w[18:13]});
    chk("count_issue", {16'd0, instr_count}, {16'd0, exp_count});
    set_sel(p1, of, cs, tk, offv, tgt);
    stall = 1'b1;
    for (int s = 0; s < stalls; s++) begin
      imem_ack   = 1'b1;
      imem_rdata = ~w;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", {13'd0, instr}, {13'd0, w});
      chk("stall_pc", {20'd0, pc}, {20'd0, a});
      chk("stall_count", {16'd0, instr_count}, {16'd0, exp_count});
    end
    stall = 1'b0;
    @(negedge clk);
    set_sel(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0);
    exp_count = exp_count + 16'd1;
    chk("count_after", {16'd0, instr_count}, {16'd0, exp_count});
    chk("req_after", {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_count  = 16'd0;
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 19'd0;
    stall      = 1'b0;
    set_sel(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0);

    //               start   p1    of    cs    tk    off     tgt      exp     err
    vecs[0]  = '{12'd10,  1'b0, 1'b1, 1'b0, 1'b1, 8'hFD, 12'h000, 12'd8,   1'b0};
    vecs[1]  = '{12'd10,  1'b0, 1'b1, 1'b0, 1'b0, 8'hFD, 12'h000, 12'd11,  1'b0};
    vecs[2]  = '{12'd10,  1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 12'h000, 12'd16,  1'b0};
    vecs[3]  = '{12'h100, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 12'h3A0, 12'h3A0, 1'b0};
    vecs[4]  = '{12'hFFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000, 12'h000, 1'b0};
    vecs[5]  = '{12'd2,   1'b0, 1'b1, 1'b0, 1'b1, 8'hFB, 12'h000, 12'hFFE, 1'b0};
    vecs[6]  = '{12'd20,  1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 12'h055, 12'h055, 1'b1};
    vecs[7]  = '{12'd30,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000, 12'd31,  1'b1};
    vecs[8]  = '{12'd40,  1'b0, 1'b1, 1'b1, 1'b1, 8'h04, 12'h200, 12'h200, 1'b1};
    vecs[9]  = '{12'd50,  1'b1, 1'b1, 1'b0, 1'b1, 8'h04, 12'h000, 12'd55,  1'b1};
    vecs[10] = '{12'd60,  1'b0, 1'b1, 1'b0, 1'b1, 8'h7F, 12'h000, 12'd188, 1'b0};
    vecs[11] = '{12'd70,  1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 12'h000, 12'hFC7, 1'b0};

    // Reset state
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", {20'd0, pc}, 32'd0);
    chk("rst_instr", {13'd0, instr}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_sel_err", {31'd0, sel_error}, 32'd0);
    chk("rst_count", {16'd0, instr_count}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);

    // Zero-wait memory, plus1: addresses 0,1,2,3
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", {20'd0, imem_addr}, i);
      run_instr(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0, 0);
    end
    chk("count4", {16'd0, instr_count}, 32'd4);
    chk("addr4", {20'd0, imem_addr}, 32'd4);

    // Ack latency of 3 cycles
    run_instr(3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0, 0);
    chk("lat_addr", {20'd0, imem_addr}, 32'd5);

    // Branch / jump vector table
    for (int v = 0; v < 12; v++) begin
      run_instr(0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, vecs[v].start_pc, 0);
      chk("vec_start", {20'd0, imem_addr}, {20'd0, vecs[v].start_pc});
      run_instr(0, vecs[v].p1, vecs[v].of, vecs[v].cs, vecs[v].tk, vecs[v].offv, vecs[v].tgt, 0);
      chk($sformatf("vec%0d_addr", v), {20'd0, imem_addr}, {20'd0, vecs[v].exp_addr});
      chk($sformatf("vec%0d_sel_err", v), {31'd0, sel_error}, {31'd0, vecs[v].exp_err});
    end

    // Stall for 3 ISSUE cycles with stray acks, then plus1
    chk("stall_pre", {20'd0, imem_addr}, 32'hFC7);
    run_instr(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0, 3);
    chk("stall_next", {20'd0, imem_addr}, 32'hFC8);

    // Async reset in the middle of a FETCH wait
    imem_ack = 1'b0;
    @(negedge clk);
    chk("mf_req_before", {31'd0, imem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mf_req_drop", {31'd0, imem_req}, 32'd0);
    chk("mf_pc", {20'd0, pc}, 32'd0);
    chk("mf_count", {16'd0, instr_count}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = word(12'h123);
    @(negedge clk);
    chk("mf_instr_rst", {13'd0, instr}, 32'd0);
    rst = 1'b0;
    exp_count = 16'd0;
    #1;
    chk("mf_idle_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("mf_instr_ign", {13'd0, instr}, 32'd0);
    chk("mf_valid_ign", {31'd0, instr_valid}, 32'd0);
    chk("mf_addr0", {20'd0, imem_addr}, 32'd0);
    run_instr(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 12'd0, 0);
    chk("mf_addr1", {20'd0, imem_addr}, 32'd1);

    // Async reset during ISSUE discards the instruction
    imem_ack   = 1'b1;
    imem_rdata = word(12'd1);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("mi_valid_before", {31'd0, instr_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mi_valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("mi_count", {16'd0, instr_count}, 32'd0);
    chk("mi_instr", {13'd0, instr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mi_req", {31'd0, imem_req}, 32'd1);
    chk("mi_addr0", {20'd0, imem_addr}, 32'd0);
    chk("mi_count_after", {16'd0, instr_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
